// File: rtl/ccip_c0_rdreq_buffer.sv
// Egress buffer for CCI-P c0 read requests: queues AFU headers and issues them
// only while the platform has room and the outstanding-read budget allows.
module ccip_c0_rdreq_buffer #(
  parameter int HDR_W     = 74,
  parameter int DEPTH     = 8,
  parameter int MAX_OUTST = 64
) (
  input  logic                         pClk,
  input  logic                         pck_cp2af_softReset_n,
  input  logic                         req_valid,
  input  logic [HDR_W-1:0]             req_hdr,
  output logic                         req_ready,
  input  logic                         c0TxAlmFull,
  input  logic                         rsp_valid,
  output logic                         tx_valid,
  output logic [HDR_W-1:0]             tx_hdr,
  output logic [$clog2(DEPTH):0]       fifo_count,
  output logic [$clog2(MAX_OUTST):0]   outst_count,
  output logic                         err_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;

  logic [HDR_W-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    fifo_count_q, fifo_count_d;
  logic [OW-1:0]    outst_count_q, outst_count_d;
  logic             err_q, err_d;
  logic             tx_valid_q, tx_valid_d;
  logic [HDR_W-1:0] tx_hdr_q, tx_hdr_d;

  logic push;
  logic issue;

  // Both handshakes depend only on registered state plus their own inputs.
  assign req_ready = (fifo_count_q < CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign issue     = (fifo_count_q != '0) && !c0TxAlmFull &&
                     (outst_count_q < OW'(MAX_OUTST));

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_count_d  = fifo_count_q;
    outst_count_d = outst_count_q;
    err_d         = err_q;
    tx_valid_d    = 1'b0;
    tx_hdr_d      = tx_hdr_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (issue) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      tx_valid_d = 1'b1;
      tx_hdr_d   = mem_q[rd_ptr_q];
    end

    case ({push, issue})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    // A response that arrives with nothing in flight saturates at zero and flags.
    case ({issue, rsp_valid})
      2'b10: outst_count_d = outst_count_q + OW'(1);
      2'b01: begin
        if (outst_count_q == '0) begin
          err_d = 1'b1;
        end else begin
          outst_count_d = outst_count_q - OW'(1);
        end
      end
      default: outst_count_d = outst_count_q;
    endcase
  end

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_count_q  <= '0;
      outst_count_q <= '0;
      err_q         <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_hdr_q      <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_count_q  <= fifo_count_d;
      outst_count_q <= outst_count_d;
      err_q         <= err_d;
      tx_valid_q    <= tx_valid_d;
      tx_hdr_q      <= tx_hdr_d;
    end
  end

  // Storage is left unreset; the count and pointers decide what is valid.
  always_ff @(posedge pClk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= req_hdr;
    end
  end

  assign tx_valid      = tx_valid_q;
  assign tx_hdr        = tx_hdr_q;
  assign fifo_count    = fifo_count_q;
  assign outst_count   = outst_count_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_ccip_c0_rdreq_buffer.sv
// Bench for ccip_c0_rdreq_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ccip_c0_rdreq_buffer;

  localparam int HDR_W     = 74;
  localparam int DEPTH     = 8;
  localparam int MAX_OUTST = 4;

  logic                       pClk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       reqValid = 1'b0;
  logic [HDR_W-1:0]           reqHdr = '0;
  logic                       reqReady;
  logic                       almFull = 1'b0;
  logic                       rspValid = 1'b0;
  logic                       txValid;
  logic [HDR_W-1:0]           txHdr;
  logic [$clog2(DEPTH):0]     fifoCount;
  logic [$clog2(MAX_OUTST):0] outstCount;
  logic                       errUnderflow;

  int nVectors = 0;
  int nMiscompares = 0;

  logic [HDR_W-1:0] mFifo[$];
  int               mOutst = 0;
  bit               mErr = 1'b0;
  bit               mValid = 1'b0;
  logic [HDR_W-1:0] mHdr = '0;

  ccip_c0_rdreq_buffer #(
    .HDR_W(HDR_W), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .pClk                  (pClk),
    .pck_cp2af_softReset_n (rst_n),
    .req_valid             (reqValid),
    .req_hdr               (reqHdr),
    .req_ready             (reqReady),
    .c0TxAlmFull           (almFull),
    .rsp_valid             (rspValid),
    .tx_valid              (txValid),
    .tx_hdr                (txHdr),
    .fifo_count            (fifoCount),
    .outst_count           (outstCount),
    .err_underflow         (errUnderflow)
  );

  always #5 pClk = ~pClk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; rspMode 2 answers whatever the model has in flight.
  task automatic applyStimulus(input bit v, input logic [HDR_W-1:0] h, input bit af, input int rspMode);
    @(negedge pClk);
    reqValid = v;
    reqHdr   = h;
    almFull  = af;
    rspValid = (rspMode == 2) ? (mOutst > 0) : (rspMode == 1);
  endtask

  task automatic afterEdge();
    @(posedge pClk);
    #3;
  endtask

  // Reference model: a queue of headers and a counter of reads in flight.
  initial begin : model
    bit canIssue;
    bit canPush;
    forever begin
      @(posedge pClk or negedge rst_n);
      if (!rst_n) begin
        mFifo.delete();
        mOutst = 0;
        mErr   = 1'b0;
        mValid = 1'b0;
        mHdr   = '0;
      end else begin
        canIssue = (mFifo.size() != 0) && !almFull && (mOutst < MAX_OUTST);
        canPush  = reqValid && (mFifo.size() < DEPTH);
        mValid   = canIssue;
        if (canIssue) mHdr = mFifo.pop_front();
        if (canPush) mFifo.push_back(reqHdr);
        if (canIssue && !rspValid) mOutst++;
        else if (rspValid && !canIssue) begin
          if (mOutst == 0) mErr = 1'b1;
          else mOutst--;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(posedge pClk);
      #1;
      if (rst_n) begin
        checkOutput("tx_valid", 128'(txValid), 128'(mValid));
        checkOutput("tx_hdr", 128'(txHdr), 128'(mHdr));
        checkOutput("fifo_count", 128'(fifoCount), 128'(mFifo.size()));
        checkOutput("outst_count", 128'(outstCount), 128'(mOutst));
        checkOutput("err_underflow", 128'(errUnderflow), 128'(mErr));
        checkOutput("req_ready", 128'(reqReady), 128'(mFifo.size() < DEPTH));
      end
    end
  end

  initial begin : stimulus
    #3;
    checkOutput("rst tx_valid", 128'(txValid), 128'(0));
    checkOutput("rst fifo_count", 128'(fifoCount), 128'(0));
    checkOutput("rst req_ready", 128'(reqReady), 128'(1));
    repeat (2) @(negedge pClk);
    rst_n = 1'b1;

    // Three back-to-back pushes leave two cycles later in order.
    applyStimulus(1, 74'h1, 0, 0);
    applyStimulus(1, 74'h2, 0, 0);
    afterEdge();
    checkOutput("t1 pulse1 valid", 128'(txValid), 128'(1));
    checkOutput("t1 pulse1 hdr", 128'(txHdr), 128'(1));
    applyStimulus(1, 74'h3, 0, 0);
    afterEdge();
    checkOutput("t1 pulse2 hdr", 128'(txHdr), 128'(2));
    applyStimulus(0, '0, 0, 0);
    afterEdge();
    checkOutput("t1 pulse3 hdr", 128'(txHdr), 128'(3));
    applyStimulus(0, '0, 0, 0);
    afterEdge();
    checkOutput("t1 idle valid", 128'(txValid), 128'(0));
    checkOutput("t1 outst", 128'(outstCount), 128'(3));
    checkOutput("t1 fifo", 128'(fifoCount), 128'(0));
    repeat (4) applyStimulus(0, '0, 0, 2);

    // Fill completely under back-pressure, then drain in order.
    for (int i = 0; i < 8; i++) applyStimulus(1, HDR_W'(32'h10 + i), 1, 0);
    applyStimulus(1, 74'h99, 1, 0);
    afterEdge();
    checkOutput("t2 full count", 128'(fifoCount), 128'(8));
    checkOutput("t2 full ready", 128'(reqReady), 128'(0));
    checkOutput("t2 held valid", 128'(txValid), 128'(0));
    applyStimulus(0, '0, 0, 2);
    afterEdge();
    checkOutput("t2 first hdr", 128'(txHdr), 128'(32'h10));
    checkOutput("t2 ready back", 128'(reqReady), 128'(1));
    repeat (12) applyStimulus(0, '0, 0, 2);

    // Budget of four reads in flight caps issue until a response arrives.
    for (int i = 0; i < 6; i++) applyStimulus(1, HDR_W'(32'h20 + i), 0, 0);
    repeat (6) applyStimulus(0, '0, 0, 0);
    afterEdge();
    checkOutput("t3 outst cap", 128'(outstCount), 128'(4));
    checkOutput("t3 fifo left", 128'(fifoCount), 128'(2));
    applyStimulus(0, '0, 0, 1);
    afterEdge();
    checkOutput("t3 outst dec", 128'(outstCount), 128'(3));
    checkOutput("t3 no issue", 128'(txValid), 128'(0));
    applyStimulus(0, '0, 0, 0);
    afterEdge();
    checkOutput("t3 resume hdr", 128'(txHdr), 128'(32'h24));
    checkOutput("t3 outst full", 128'(outstCount), 128'(4));
    repeat (10) applyStimulus(0, '0, 0, 2);

    // Response coinciding with an issue at zero in flight is not an error.
    applyStimulus(1, 74'h40, 0, 0);
    applyStimulus(0, '0, 0, 1);
    afterEdge();
    checkOutput("t5 co hdr", 128'(txHdr), 128'(32'h40));
    checkOutput("t5 co outst", 128'(outstCount), 128'(0));
    checkOutput("t5 co err", 128'(errUnderflow), 128'(0));

    // Steady push+issue at occupancy five wraps the pointers.
    for (int i = 0; i < 5; i++) applyStimulus(1, HDR_W'(32'h30 + i), 1, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, HDR_W'(32'h50 + i), 0, 2);
    applyStimulus(0, '0, 1, 2);
    afterEdge();
    checkOutput("t4 steady count", 128'(fifoCount), 128'(5));
    repeat (10) applyStimulus(0, '0, 0, 2);

    // Underflow flag is sticky.
    applyStimulus(0, '0, 0, 1);
    afterEdge();
    checkOutput("t5 err set", 128'(errUnderflow), 128'(1));
    checkOutput("t5 outst zero", 128'(outstCount), 128'(0));
    repeat (3) applyStimulus(0, '0, 0, 0);
    afterEdge();
    checkOutput("t5 err sticky", 128'(errUnderflow), 128'(1));

    // Asynchronous reset mid-operation.
    applyStimulus(1, 74'h60, 0, 0);
    applyStimulus(1, 74'h61, 0, 0);
    applyStimulus(0, '0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, HDR_W'(32'h70 + i), 1, 0);
    afterEdge();
    checkOutput("t6 pre fifo", 128'(fifoCount), 128'(4));
    checkOutput("t6 pre outst", 128'(outstCount), 128'(2));
    @(negedge pClk);
    #2;
    rst_n    = 1'b0;
    reqValid = 1'b0;
    almFull  = 1'b0;
    rspValid = 1'b0;
    #1;
    checkOutput("t6 async valid", 128'(txValid), 128'(0));
    checkOutput("t6 async hdr", 128'(txHdr), 128'(0));
    checkOutput("t6 async fifo", 128'(fifoCount), 128'(0));
    checkOutput("t6 async outst", 128'(outstCount), 128'(0));
    checkOutput("t6 async err", 128'(errUnderflow), 128'(0));
    @(negedge pClk);
    rst_n = 1'b1;
    repeat (3) applyStimulus(0, '0, 0, 0);
    afterEdge();
    checkOutput("t6 no stale", 128'(txValid), 128'(0));
    checkOutput("t6 ready", 128'(reqReady), 128'(1));

    repeat (2) applyStimulus(0, '0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/ccip_c0_rdreq_buffer.md
Name: ccip_c0_rdreq_buffer

Overview:
- AFU-side egress stage sitting directly upstream of the CCI-P Tx channel 0 (pck_af2cp_sTx.c0) that feeds the CCI-P emulator.
- Buffers AFU read-request headers in a FIFO and issues them onto c0 only when the platform is not asserting c0TxAlmFull and the outstanding-read budget has room.
- Tracks in-flight reads by counting c0 read responses from pck_cp2af_sRx.

Parameters:
- HDR_W, 74, width of the c0 request header (t_ccip_c0_ReqMemHdr)
- DEPTH, 8, FIFO entries; power of 2, ≥2
- MAX_OUTST, 64, maximum reads in flight; ≥1

Ports:
- pClk  in  1  CCI-P primary clock; all logic on rising edge
- pck_cp2af_softReset_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  AFU request present
- req_hdr  in  HDR_W  AFU request header
- req_ready  out  1  FIFO can accept; transfer when req_valid&&req_ready
- c0TxAlmFull  in  1  platform back-pressure, from sRx
- rsp_valid  in  1  c0 read response received (sRx.c0.rspValid && resp_type==read)
- tx_valid  out  1  drives sTx.c0.valid
- tx_hdr  out  HDR_W  drives sTx.c0.hdr
- fifo_count  out  $clog2(DEPTH)+1  entries currently buffered
- outst_count  out  $clog2(MAX_OUTST)+1  reads in flight
- err_underflow  out  1  sticky: response seen with outst_count==0

Behaviour:
- Reset (async, pck_cp2af_softReset_n=0): tx_valid=0, tx_hdr=0, fifo_count=0, outst_count=0, err_underflow=0, rd/wr pointers=0. Reset mid-operation discards buffered entries and in-flight count.
- Storage: DEPTH-entry circular FIFO; wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH; fully registered count avoids full/empty ambiguity.
- req_ready = (fifo_count < DEPTH), combinational from registered state only. It is never a function of req_valid.
- Push: req_valid && req_ready → write req_hdr at wr_ptr, wr_ptr+1.
- Issue condition (evaluated each cycle on current registered state and current inputs): issue = (fifo_count!=0) && !c0TxAlmFull && (outst_count < MAX_OUTST).
- On issue: tx_hdr ← mem[rd_ptr], tx_valid ← 1 at next edge; rd_ptr+1. Otherwise tx_valid ← 0 and tx_hdr holds its last value. tx_valid is a single-cycle pulse per request; back-to-back issues give consecutive pulses.
- Latency: a push into an empty FIFO with issue conditions true appears on tx_valid 2 cycles later (cycle N write, cycle N+1 issue decision, cycle N+2 tx_valid=1). No same-cycle bypass.
- c0TxAlmFull: the first cycle it is seen high blocks issue. At most one already-decided request (registered in that edge) leaves after assertion, which is within CCI-P slack.
- fifo_count: +1 on push only, −1 on issue only, unchanged if both or neither. Push and issue in the same cycle are legal at any occupancy where req_ready=1. When full, req_ready=0, so a same-cycle issue frees a slot usable next cycle.
- outst_count: +1 on issue only, −1 on rsp_valid only, unchanged if both.
- rsp_valid with outst_count==0 and no same-cycle issue: count stays 0 (no wrap) and err_underflow ← 1 (sticky until reset).
- rsp_valid with outst_count==0 and a simultaneous issue: count stays 0 and no error is flagged.
- outst_count==MAX_OUTST: issue is blocked. A rsp_valid in that cycle decrements the count, so issue can resume the following cycle.
- No combinational path from any input to tx_valid/tx_hdr.

Test Plan:
- Reset, then 3 pushes of hdr 0x1,0x2,0x3 on consecutive cycles with c0TxAlmFull=0 → tx_valid pulses on cycles 2,3,4 carrying 0x1,0x2,0x3; outst_count=3; fifo_count returns to 0.
- Hold c0TxAlmFull=1 and push 8 headers → req_ready=0 after the 8th, fifo_count=8, tx_valid stays 0. Drop almfull → 8 pulses in FIFO order, req_ready reasserts the cycle after the first issue.
- MAX_OUTST=4: push 6 with no responses → exactly 4 issued, outst_count=4, fifo_count=2. Pulse rsp_valid once → one more issue the next cycle, outst_count back to 4.
- Concurrent push and issue at fifo_count=5 for 20 cycles → fifo_count stays 5, pointers wrap past DEPTH, output order matches input order.
- rsp_valid with outst_count=0 → err_underflow=1, outst_count=0; err_underflow remains 1 until reset.
- Assert reset with fifo_count=4 and outst_count=2 → all outputs 0 immediately (asynchronous); after release, no stale tx_valid and req_ready=1.
